// File: rtl/corrector_pkg.sv
// Shared types and helpers for the read-correction output path.
// Slot lifecycle states and base-encoding width used by the candidate queue.
package corrector_pkg;

    typedef enum logic [1:0] {
        SLOT_EMPTY,
        SLOT_FILLING,
        SLOT_FULL,
        SLOT_DRAINING
    } slot_state_t;

    localparam int BASE_BITS = 2;

    // A count field must also represent the full depth value itself.
    function automatic int count_width(input int cand_bits);
        return cand_bits + 1;
    endfunction

endpackage

// File: rtl/candidate_slot.sv
// One group slot: collects a candidate group, latches its read/count,
// then replays the stored candidates one beat at a time.
module candidate_slot
    import corrector_pkg::*;
#(
    parameter int CAND_BIT_WIDTH = 5,
    parameter int MAX_CANDS      = 2**CAND_BIT_WIDTH,
    parameter int DATA_W         = 512
) (
    input  logic                                      clk,
    input  logic                                      rstb,
    input  logic                                      wr_en_i,
    input  logic [DATA_W-1:0]                         wr_data_i,
    input  logic [DATA_W-1:0]                         wr_read_i,
    input  logic [count_width(CAND_BIT_WIDTH)-1:0]    wr_count_i,
    input  logic                                      rd_en_i,
    output slot_state_t                               state_o,
    output logic                                      wr_last_o,
    output logic [DATA_W-1:0]                         rd_data_o,
    output logic [DATA_W-1:0]                         rd_read_o,
    output logic [count_width(CAND_BIT_WIDTH)-1:0]    rd_count_o,
    output logic                                      rd_first_o,
    output logic                                      rd_last_o,
    output logic                                      rd_overflow_o
);

    localparam int CW = count_width(CAND_BIT_WIDTH);
    localparam logic [CW-1:0] MAX_CANDS_C = CW'(MAX_CANDS);
    localparam logic [CW-1:0] ONE_C       = CW'(1);

    slot_state_t                state_q;
    logic [CW-1:0]              cnt_q;
    logic [CW-1:0]              stored_q;
    logic                       ovf_q;
    logic [DATA_W-1:0]          read_q;
    logic [CW-1:0]              wr_idx_q;
    logic [CAND_BIT_WIDTH-1:0]  rd_idx_q;
    logic [DATA_W-1:0]          mem_q [MAX_CANDS];

    logic [CW-1:0]              stored_d;
    logic                       store_en;
    logic [CAND_BIT_WIDTH-1:0]  store_idx;

    always_comb begin
        stored_d  = (wr_count_i > MAX_CANDS_C) ? MAX_CANDS_C : wr_count_i;
        store_en  = 1'b0;
        store_idx = '0;
        wr_last_o = 1'b0;
        if (state_q == SLOT_EMPTY) begin
            store_en  = wr_en_i && (wr_count_i != '0);
            wr_last_o = (wr_count_i <= ONE_C);
        end else if (state_q == SLOT_FILLING) begin
            // Beats past the slot depth are accepted but dropped.
            store_en  = wr_en_i && (wr_idx_q < MAX_CANDS_C);
            store_idx = wr_idx_q[CAND_BIT_WIDTH-1:0];
            wr_last_o = (wr_idx_q == cnt_q - ONE_C);
        end
    end

    always_comb begin
        state_o       = state_q;
        rd_first_o    = (rd_idx_q == '0);
        rd_last_o     = (stored_q <= ONE_C) || ({1'b0, rd_idx_q} == stored_q - ONE_C);
        rd_data_o     = (stored_q == '0) ? '0 : mem_q[rd_idx_q];
        rd_read_o     = read_q;
        rd_count_o    = stored_q;
        rd_overflow_o = ovf_q;
    end

    always_ff @(posedge clk) begin
        if (store_en) begin
            mem_q[store_idx] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q  <= SLOT_EMPTY;
            cnt_q    <= '0;
            stored_q <= '0;
            ovf_q    <= 1'b0;
            read_q   <= '0;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
        end else begin
            case (state_q)
                SLOT_EMPTY: begin
                    if (wr_en_i) begin
                        cnt_q    <= wr_count_i;
                        stored_q <= stored_d;
                        ovf_q    <= (wr_count_i > MAX_CANDS_C);
                        read_q   <= wr_read_i;
                        wr_idx_q <= ONE_C;
                        rd_idx_q <= '0;
                        state_q  <= (wr_count_i <= ONE_C) ? SLOT_FULL : SLOT_FILLING;
                    end
                end
                SLOT_FILLING: begin
                    if (wr_en_i) begin
                        wr_idx_q <= wr_idx_q + ONE_C;
                        if (wr_last_o) begin
                            state_q <= SLOT_FULL;
                        end
                    end
                end
                SLOT_FULL, SLOT_DRAINING: begin
                    if (rd_en_i) begin
                        if (rd_last_o) begin
                            state_q  <= SLOT_EMPTY;
                            rd_idx_q <= '0;
                        end else begin
                            state_q  <= SLOT_DRAINING;
                            rd_idx_q <= rd_idx_q + 1'b1;
                        end
                    end
                end
                default: state_q <= SLOT_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/candidate_group_queue.sv
// Ring of candidate group slots: groups are written in arrival order and only
// released to the consumer once complete, one candidate per beat.
module candidate_group_queue
    import corrector_pkg::*;
#(
    parameter int MAX_READ_BIT_WIDTH  = 8,
    parameter int MAX_READ_LEN        = 2**MAX_READ_BIT_WIDTH,
    parameter int CAND_BIT_WIDTH      = 5,
    parameter int MAX_CANDS           = 2**CAND_BIT_WIDTH,
    parameter int NUM_SLOTS_BIT_WIDTH = 3,
    parameter int NUM_SLOTS           = 2**NUM_SLOTS_BIT_WIDTH
) (
    input  logic                                    clk,
    input  logic                                    rstb,
    input  logic [BASE_BITS*MAX_READ_LEN-1:0]       in_candidate,
    input  logic [BASE_BITS*MAX_READ_LEN-1:0]       in_read,
    input  logic [count_width(CAND_BIT_WIDTH)-1:0]  in_count,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    output logic [BASE_BITS*MAX_READ_LEN-1:0]       out_candidate,
    output logic [BASE_BITS*MAX_READ_LEN-1:0]       out_read,
    output logic [count_width(CAND_BIT_WIDTH)-1:0]  out_count,
    output logic                                    out_valid,
    output logic                                    out_first,
    output logic                                    out_last,
    output logic                                    out_overflow,
    input  logic                                    out_ready,
    output logic [NUM_SLOTS_BIT_WIDTH:0]            slots_free
);

    localparam int DATA_W = BASE_BITS * MAX_READ_LEN;
    localparam int CW     = count_width(CAND_BIT_WIDTH);
    localparam int PW     = NUM_SLOTS_BIT_WIDTH;
    localparam int FW     = NUM_SLOTS_BIT_WIDTH + 1;

    logic [PW-1:0]      wr_ptr_q;
    logic [PW-1:0]      rd_ptr_q;
    logic               live_q;

    slot_state_t        slot_state    [NUM_SLOTS];
    logic               slot_wr_last  [NUM_SLOTS];
    logic [DATA_W-1:0]  slot_data     [NUM_SLOTS];
    logic [DATA_W-1:0]  slot_read     [NUM_SLOTS];
    logic [CW-1:0]      slot_count    [NUM_SLOTS];
    logic               slot_first    [NUM_SLOTS];
    logic               slot_rd_last  [NUM_SLOTS];
    logic               slot_overflow [NUM_SLOTS];

    logic               wr_fire;
    logic               rd_fire;
    logic [FW-1:0]      free_cnt;

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        candidate_slot #(
            .CAND_BIT_WIDTH (CAND_BIT_WIDTH),
            .MAX_CANDS      (MAX_CANDS),
            .DATA_W         (DATA_W)
        ) u_slot (
            .clk           (clk),
            .rstb          (rstb),
            .wr_en_i       (wr_fire && (wr_ptr_q == PW'(g))),
            .wr_data_i     (in_candidate),
            .wr_read_i     (in_read),
            .wr_count_i    (in_count),
            .rd_en_i       (rd_fire && (rd_ptr_q == PW'(g))),
            .state_o       (slot_state[g]),
            .wr_last_o     (slot_wr_last[g]),
            .rd_data_o     (slot_data[g]),
            .rd_read_o     (slot_read[g]),
            .rd_count_o    (slot_count[g]),
            .rd_first_o    (slot_first[g]),
            .rd_last_o     (slot_rd_last[g]),
            .rd_overflow_o (slot_overflow[g])
        );
    end

    // Input is held off for the first cycle after reset so in_ready reads 0 there.
    always_comb begin
        in_ready = live_q && ((slot_state[wr_ptr_q] == SLOT_EMPTY) ||
                              (slot_state[wr_ptr_q] == SLOT_FILLING));
        wr_fire  = in_valid && in_ready;
        out_valid = (slot_state[rd_ptr_q] == SLOT_FULL) ||
                    (slot_state[rd_ptr_q] == SLOT_DRAINING);
        rd_fire  = out_valid && out_ready;
    end

    always_comb begin
        out_candidate = '0;
        out_read      = '0;
        out_count     = '0;
        out_first     = 1'b0;
        out_last      = 1'b0;
        out_overflow  = 1'b0;
        if (out_valid) begin
            out_candidate = slot_data[rd_ptr_q];
            out_read      = slot_read[rd_ptr_q];
            out_count     = slot_count[rd_ptr_q];
            out_first     = slot_first[rd_ptr_q];
            out_last      = slot_rd_last[rd_ptr_q];
            out_overflow  = slot_overflow[rd_ptr_q];
        end
    end

    always_comb begin
        free_cnt = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slot_state[i] == SLOT_EMPTY) begin
                free_cnt = free_cnt + FW'(1);
            end
        end
        slots_free = free_cnt;
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            live_q   <= 1'b0;
        end else begin
            live_q <= 1'b1;
            if (wr_fire && slot_wr_last[wr_ptr_q]) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (rd_fire && slot_rd_last[rd_ptr_q]) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_candidate_group_queue.sv
// Self-checking bench for candidate_group_queue: a table of groups plus
// hand-written sequences, with a scoreboard of expected output beats.
module tb_candidate_group_queue;

    localparam int DW = 512;
    localparam int CW = 6;

    typedef struct {
        logic [DW-1:0] cand;
        logic [DW-1:0] rd;
        logic [CW-1:0] cnt;
        logic          first;
        logic          last;
        logic          ovf;
    } beat_t;

    typedef struct {
        int count;
        int tag;
        int expBeats;
        int expCount;
        bit expOvf;
    } vec_t;

    logic          clk = 1'b0;
    logic          rstb;
    logic [DW-1:0] in_candidate;
    logic [DW-1:0] in_read;
    logic [CW-1:0] in_count;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_candidate;
    logic [DW-1:0] out_read;
    logic [CW-1:0] out_count;
    logic          out_valid;
    logic          out_first;
    logic          out_last;
    logic          out_overflow;
    logic          out_ready;
    logic [3:0]    slots_free;

    beat_t         expQ[$];
    vec_t          vecs[8];
    int            total = 0;
    int            bad = 0;
    bit            monOn = 1'b0;
    logic          prevStall = 1'b0;
    logic [DW-1:0] prevCand = '0;
    logic          prevLast = 1'b0;

    candidate_group_queue dut (
        .clk           (clk),
        .rstb          (rstb),
        .in_candidate  (in_candidate),
        .in_read       (in_read),
        .in_count      (in_count),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_candidate (out_candidate),
        .out_read      (out_read),
        .out_count     (out_count),
        .out_valid     (out_valid),
        .out_first     (out_first),
        .out_last      (out_last),
        .out_overflow  (out_overflow),
        .out_ready     (out_ready),
        .slots_free    (slots_free)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] makeData(input int tag, input int idx);
        logic [31:0] w;
        w = 32'(tag) * 32'h10000 + 32'(idx) + 32'h1;
        return {(DW/32){w}};
    endfunction

    function automatic logic [DW-1:0] makeRead(input int tag);
        logic [31:0] w;
        w = 32'(tag) ^ 32'hC0DE0000;
        return {(DW/32){w}};
    endfunction

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic pushGroup(input int tag, input int expBeats, input int expCount, input bit expOvf);
        beat_t e;
        for (int j = 0; j < expBeats; j++) begin
            e.cand  = (expCount == 0) ? '0 : makeData(tag, j);
            e.rd    = makeRead(tag);
            e.cnt   = CW'(expCount);
            e.first = (j == 0);
            e.last  = (j == expBeats - 1);
            e.ovf   = expOvf;
            expQ.push_back(e);
        end
    endtask

    task automatic driveBeat(input logic [DW-1:0] c, input logic [DW-1:0] r, input logic [CW-1:0] n);
        int waitCycles = 0;
        in_valid     = 1'b1;
        in_candidate = c;
        in_read      = r;
        in_count     = n;
        @(negedge clk);
        while (!in_ready && waitCycles < 500) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!in_ready) checkOutput("in_ready_timeout", DW'(in_ready), DW'(1'b1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Non-first beats carry junk read/count that the queue must ignore.
    task automatic applyStimulus(input int count, input int tag, input int expBeats,
                                 input int expCount, input bit expOvf);
        int nBeats;
        pushGroup(tag, expBeats, expCount, expOvf);
        nBeats = (count == 0) ? 1 : count;
        for (int i = 0; i < nBeats; i++) begin
            if (i == 0) driveBeat(makeData(tag, i), makeRead(tag), CW'(count));
            else        driveBeat(makeData(tag, i), ~makeRead(tag), CW'($urandom_range(0, 63)));
        end
    endtask

    task automatic waitDrain();
        int n = 0;
        while (expQ.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (expQ.size() != 0) checkOutput("drain_timeout", DW'(expQ.size()), '0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (monOn && rstb && prevStall) begin
            checkOutput("stall_valid", DW'(out_valid), DW'(1'b1));
            checkOutput("stall_cand", out_candidate, prevCand);
            checkOutput("stall_last", DW'(out_last), DW'(prevLast));
        end
        if (monOn && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_beat", DW'(expQ.size()), DW'(1));
            end else begin
                checkOutput("beat_cand", out_candidate, expQ[0].cand);
                checkOutput("beat_read", out_read, expQ[0].rd);
                checkOutput("beat_count", DW'(out_count), DW'(expQ[0].cnt));
                checkOutput("beat_first", DW'(out_first), DW'(expQ[0].first));
                checkOutput("beat_last", DW'(out_last), DW'(expQ[0].last));
                checkOutput("beat_ovf", DW'(out_overflow), DW'(expQ[0].ovf));
                expQ.delete(0);
            end
        end
        prevStall <= monOn && rstb && out_valid && !out_ready;
        prevCand  <= out_candidate;
        prevLast  <= out_last;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{1, 10, 1, 1, 1'b0};
        vecs[1] = '{0, 11, 1, 0, 1'b0};
        vecs[2] = '{1, 12, 1, 1, 1'b0};
        vecs[3] = '{40, 13, 32, 32, 1'b1};
        vecs[4] = '{3, 14, 3, 3, 1'b0};
        vecs[5] = '{32, 15, 32, 32, 1'b0};
        vecs[6] = '{33, 16, 32, 32, 1'b1};
        vecs[7] = '{2, 17, 2, 2, 1'b0};

        rstb = 1'b0;
        in_valid = 1'b0;
        in_candidate = '0;
        in_read = '0;
        in_count = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", DW'(in_ready), '0);
        checkOutput("rst_out_valid", DW'(out_valid), '0);
        checkOutput("rst_first", DW'(out_first), '0);
        checkOutput("rst_last", DW'(out_last), '0);
        checkOutput("rst_ovf", DW'(out_overflow), '0);
        checkOutput("rst_cand", out_candidate, '0);
        checkOutput("rst_read", out_read, '0);
        checkOutput("rst_count", DW'(out_count), '0);
        checkOutput("rst_free", DW'(slots_free), DW'(8));
        monOn = 1'b1;
        rstb = 1'b1;

        $display("[TB] single 3-candidate group and latency");
        pushGroup(1, 3, 3, 1'b0);
        driveBeat(makeData(1, 0), makeRead(1), CW'(3));
        driveBeat(makeData(1, 1), ~makeRead(1), CW'(9));
        in_valid = 1'b1;
        in_candidate = makeData(1, 2);
        in_read = ~makeRead(1);
        in_count = CW'(0);
        @(negedge clk);
        checkOutput("lat_before_valid", DW'(out_valid), '0);
        checkOutput("lat_last_ready", DW'(in_ready), DW'(1'b1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("lat_after_valid", DW'(out_valid), DW'(1'b1));
        checkOutput("lat_after_first", DW'(out_first), DW'(1'b1));
        waitDrain();
        checkOutput("t1_free", DW'(slots_free), DW'(8));

        $display("[TB] fill all slots while stalled");
        out_ready = 1'b0;
        for (int g = 0; g < 8; g++) applyStimulus(2, 20 + g, 2, 2, 1'b0);
        @(negedge clk);
        checkOutput("full_in_ready", DW'(in_ready), '0);
        checkOutput("full_free", DW'(slots_free), '0);
        checkOutput("full_out_valid", DW'(out_valid), DW'(1'b1));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            checkOutput("burst_no_bubble", DW'(out_valid), DW'(1'b1));
            if (i < 2) checkOutput("burst_ready_low", DW'(in_ready), '0);
            if (i == 2) begin
                checkOutput("burst_ready_back", DW'(in_ready), DW'(1'b1));
                checkOutput("burst_free_one", DW'(slots_free), DW'(1));
            end
        end
        waitDrain();
        checkOutput("t2_free", DW'(slots_free), DW'(8));

        $display("[TB] table of groups");
        for (int v = 0; v < 8; v++) begin
            applyStimulus(vecs[v].count, vecs[v].tag, vecs[v].expBeats, vecs[v].expCount, vecs[v].expOvf);
        end
        waitDrain();
        checkOutput("table_free", DW'(slots_free), DW'(8));

        $display("[TB] random backpressure");
        fork
            applyStimulus(5, 30, 5, 5, 1'b0);
            begin
                repeat (40) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        waitDrain();

        $display("[TB] reset mid-fill");
        driveBeat(makeData(50, 0), makeRead(50), CW'(4));
        driveBeat(makeData(50, 1), ~makeRead(50), CW'(4));
        rstb = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("rfill_valid", DW'(out_valid), '0);
        checkOutput("rfill_free", DW'(slots_free), DW'(8));
        checkOutput("rfill_in_ready", DW'(in_ready), '0);
        @(posedge clk);
        #1;
        rstb = 1'b1;

        $display("[TB] reset mid-drain");
        applyStimulus(6, 51, 6, 6, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rstb = 1'b0;
        @(posedge clk);
        #1;
        expQ.delete();
        @(negedge clk);
        checkOutput("rdrain_valid", DW'(out_valid), '0);
        checkOutput("rdrain_free", DW'(slots_free), DW'(8));
        checkOutput("rdrain_cand", out_candidate, '0);
        @(posedge clk);
        #1;
        rstb = 1'b1;
        applyStimulus(2, 53, 2, 2, 1'b0);
        waitDrain();
        checkOutput("post_rst_free", DW'(slots_free), DW'(8));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/candidate_group_queue.md
Name: candidate_group_queue

Overview:
- Parametrised successor to the corrector's candidate output queue. Collects candidate groups from the correction core into NUM_SLOTS slots. A group is all candidates for one read, plus that read.
- Emits each group to the host-side consumer only once the whole group is complete, in strict arrival order, over a valid/ready stream.
- New versus the previous generation:
  - configurable slot count and slot depth;
  - first/last group framing;
  - support for zero-candidate groups;
  - overflow truncation with a flag;
  - a free-slot count.

Parameters:
- MAX_READ_BIT_WIDTH, 8, log2 of the maximum read length in bases.
- MAX_READ_LEN, 2**MAX_READ_BIT_WIDTH, read length in bases; the data bus is 2*MAX_READ_LEN bits (2 bits per base).
- CAND_BIT_WIDTH, 5, log2 of the slot depth.
- MAX_CANDS, 2**CAND_BIT_WIDTH, number of candidate entries per slot.
- NUM_SLOTS_BIT_WIDTH, 3, log2 of the slot count.
- NUM_SLOTS, 2**NUM_SLOTS_BIT_WIDTH, number of group slots.

Ports:
- clk  in  1  clock.
- rstb  in  1  synchronous active-low reset.
- in_candidate  in  2*MAX_READ_LEN  candidate sequence.
- in_read  in  2*MAX_READ_LEN  read being corrected; sampled on the first beat of a group.
- in_count  in  CAND_BIT_WIDTH+1  candidates in the group; sampled on the first beat.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid & in_ready.
- out_candidate  out  2*MAX_READ_LEN  candidate (0 for an empty group).
- out_read  out  2*MAX_READ_LEN  read of the current group.
- out_count  out  CAND_BIT_WIDTH+1  number of candidates stored for the group.
- out_valid  out  1  beat valid.
- out_first  out  1  first beat of the group.
- out_last  out  1  last beat of the group.
- out_overflow  out  1  group was truncated.
- out_ready  in  1  consumer accepts the beat.
- slots_free  out  NUM_SLOTS_BIT_WIDTH+1  slots in the EMPTY state.

Behaviour:
- Reset (rstb=0 at a clk edge):
  - all slots EMPTY; write and read slot pointers 0; beat counters 0; partial groups discarded;
  - in_ready=0, out_valid=0, out_first/last/overflow=0, data outputs 0, slots_free=NUM_SLOTS.
  - Reset mid-group or mid-drain behaves identically.
- Per-slot state: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
  - EMPTY->FILLING: first beat of a group accepted into the write slot when in_count>1. in_count and in_read are latched.
  - FILLING->FULL: beat number latched_count-1 accepted. The write pointer then advances modulo NUM_SLOTS.
  - A first beat with in_count 0 or 1 goes EMPTY->FULL directly.
  - FULL->DRAINING: slot is at the read pointer and its first beat is accepted (out_valid&out_ready).
  - DRAINING->EMPTY: last beat accepted. The read pointer advances on the same edge.
- in_ready is high iff the write slot is EMPTY or FILLING.
  - in_ready never depends on in_valid.
  - When all slots are FULL or DRAINING, in_ready=0.
- Overflow: when latched_count > MAX_CANDS, beats beyond MAX_CANDS are still accepted but discarded. Such a group has out_count=MAX_CANDS and out_overflow=1 on every beat.
- Zero-candidate group: in_count=0 consumes one input beat and stores no candidate entry.
  - Output is one beat with out_first=out_last=1, out_count=0, out_candidate=0.
- in_count and in_read on non-first beats are ignored.
- Output side:
  - out_valid is high iff the read slot is FULL or DRAINING.
  - Each beat is held stable while out_valid&~out_ready.
  - One beat per cycle at out_ready=1.
  - Beats per group = max(stored,1).
- Latency:
  - A group's first beat is visible no earlier than the cycle after its last input beat is accepted.
  - Back-to-back complete groups drain with zero bubbles.
- Simultaneous events:
  - Write and read never target the same slot in one cycle.
  - A slot freed by the read side on edge N may be written from edge N+1.
  - slots_free updates on the same edge as the state change.
- Wrap-around:
  - Pointers wrap NUM_SLOTS-1 -> 0.
  - Beat counters count to MAX_CANDS-1 for stored beats, and saturate their store index once overflow starts.

Decomposition:
- Shared package (corrector_pkg):
  - slot state enum {EMPTY, FILLING, FULL, DRAINING};
  - base-encoding width constant (2 bits per base);
  - count-width helper function.
- One natural sub-module: candidate_slot. It holds one slot's state machine, a MAX_CANDS x 2*MAX_READ_LEN store, the latched read/count/overflow, and the read index.
- The top level holds the pointers, the output muxes and slots_free.

Test Plan:
1. Reset, then write one 3-candidate group (A,B,C) with out_ready=1 -> 3 output beats A,B,C; out_first on A, out_last on C; out_count=3; first beat appears 1 cycle after C is accepted; slots_free returns to 8.
2. Fill all 8 slots with 2-candidate groups while out_ready=0 -> in_ready=0 after the 16th beat and slots_free=0. Raise out_ready -> 16 beats with no bubbles, in group order; in_ready returns 1 cycle after the first group drains.
3. Group with in_count=40 (MAX_CANDS=32) -> 40 beats accepted; 32 beats emitted with out_count=32 and out_overflow=1 throughout; the next group is unaffected.
4. in_count=0 group between two 1-candidate groups -> 3 single-beat outputs; the middle one has out_count=0, out_candidate=0, first=last=1.
5. Toggle out_ready randomly during a 5-candidate drain -> data held stable while stalled; exactly 5 beats, no duplicates.
6. Assert rstb=0 mid-fill (2 of 4 beats written) and mid-drain -> next cycle out_valid=0 and slots_free=8; a post-reset group emits correctly from slot 0.
